// File: rtl/encode_match_ctl_if.sv
// Stream, history-port and token-FIFO signals between the LZS encode datapath
// and its match controller. The controller is the slave side.
`timescale 1ns/1ps
interface encode_match_ctl_if #(
  parameter int LZF_WIDTH = 20,
  parameter int OFF_WIDTH = 11
);
  logic                 in_valid;
  logic [7:0]           in_byte;
  logic [LZF_WIDTH-1:0] in_pos;
  logic                 cand_hit;
  logic [LZF_WIDTH-1:0] cand_pos;
  logic                 data_empty;
  logic [7:0]           hdata;
  logic [OFF_WIDTH-1:0] hraddr;
  logic                 fo_full;
  logic                 tok_valid;
  logic                 tok_ready;
  logic                 tok_type;
  logic [7:0]           tok_lit;
  logic [OFF_WIDTH-1:0] tok_off;
  logic [7:0]           tok_len;
  logic                 done;

  modport master (
    output in_valid, in_byte, in_pos, cand_hit, cand_pos, data_empty, hdata, tok_ready,
    input  hraddr, fo_full, tok_valid, tok_type, tok_lit, tok_off, tok_len, done
  );

  modport slave (
    input  in_valid, in_byte, in_pos, cand_hit, cand_pos, data_empty, hdata, tok_ready,
    output hraddr, fo_full, tok_valid, tok_type, tok_lit, tok_off, tok_len, done
  );
endinterface

// File: rtl/encode_match_ctl.sv
// LZS encode match controller: literal/match decision per byte, history read
// steering for match extension, and a 4-entry first-word-fall-through token FIFO.
`timescale 1ns/1ps
module encode_match_ctl_chk #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(4);

  // A push with no free slot would silently drop a token.
  push_into_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt == DEPTH)))
    else $error("encode_match_ctl: push into full token FIFO");
endmodule

module encode_match_ctl #(
  parameter int LZF_WIDTH = 20,
  parameter int OFF_WIDTH = 11,
  parameter int MAX_LEN   = 255
) (
  input logic                clk,
  input logic                rst,
  encode_match_ctl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LIT, S_MATCH, S_FLUSH, S_DONE} state_t;

  localparam int                   TOK_W     = 1 + 8 + OFF_WIDTH + 8;
  localparam logic [LZF_WIDTH-1:0] OFF_MAX   = LZF_WIDTH'((1 << OFF_WIDTH) - 1);
  localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);

  function automatic logic [TOK_W-1:0] pack_tok(input logic t, input logic [7:0] lit,
                                                input logic [OFF_WIDTH-1:0] off,
                                                input logic [7:0] len);
    return {t, lit, off, len};
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           pend_byte_q, pend_byte_d;
  logic                 pend_v_q, pend_v_d;
  logic [OFF_WIDTH-1:0] m_off_q, m_off_d;
  logic [7:0]           m_len_q, m_len_d;
  logic [LZF_WIDTH-1:0] m_src_q, m_src_d;
  logic                 flush_m_q, flush_m_d;
  logic [OFF_WIDTH-1:0] hraddr_q, hraddr_d;
  logic                 done_q, done_d;
  logic                 fo_full_q, fo_full_d;
  logic                 tok_valid_q, tok_valid_d;
  logic [TOK_W-1:0]     mem_q [4];
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [2:0]           cnt_q, cnt_d;

  logic [LZF_WIDTH-1:0] off_s;
  logic                 usable_s;
  logic                 push_s;
  logic [TOK_W-1:0]     push_tok_s;
  logic                 pop_s;
  logic                 push_ok_s;
  logic                 room_s;
  logic [TOK_W-1:0]     head_s;

  // Negative offsets wrap to large values and fail the upper bound.
  assign off_s    = (bus.in_pos - LZF_WIDTH'(1)) - bus.cand_pos;
  assign usable_s = (off_s != '0) && (off_s <= OFF_MAX);
  assign room_s   = (cnt_q != 3'd4);

  always_comb begin
    state_d     = state_q;
    pend_byte_d = pend_byte_q;
    pend_v_d    = pend_v_q;
    m_off_d     = m_off_q;
    m_len_d     = m_len_q;
    m_src_d     = m_src_q;
    flush_m_d   = flush_m_q;
    hraddr_d    = hraddr_q;
    done_d      = done_q;
    push_s      = 1'b0;
    push_tok_s  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          pend_byte_d = bus.in_byte;
          pend_v_d    = 1'b1;
          state_d     = S_LIT;
        end else if (bus.data_empty) begin
          flush_m_d = 1'b0;
          state_d   = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LIT: begin
        if (bus.in_valid) begin
          if (bus.cand_hit && usable_s) begin
            m_len_d  = 8'd2;
            m_off_d  = off_s[OFF_WIDTH-1:0];
            m_src_d  = bus.cand_pos + LZF_WIDTH'(2);
            pend_v_d = 1'b0;
            state_d  = S_MATCH;
          end else begin
            if (pend_v_q) begin
              push_s     = 1'b1;
              push_tok_s = pack_tok(1'b0, pend_byte_q, '0, 8'd0);
            end else begin
              push_s = 1'b0;
            end
            pend_byte_d = bus.in_byte;
            pend_v_d    = 1'b1;
          end
        end else if (bus.data_empty) begin
          flush_m_d = 1'b0;
          state_d   = S_FLUSH;
        end else begin
          state_d = S_LIT;
        end
      end
      S_MATCH: begin
        if (bus.in_valid) begin
          if ((bus.in_byte == bus.hdata) && (m_len_q < MAX_LEN_B)) begin
            m_len_d = m_len_q + 8'd1;
            m_src_d = m_src_q + LZF_WIDTH'(1);
            // A maximal match closes at once; the next byte starts fresh.
            if (m_len_d == MAX_LEN_B) begin
              push_s     = 1'b1;
              push_tok_s = pack_tok(1'b1, 8'd0, m_off_q, m_len_d);
              pend_v_d   = 1'b0;
              state_d    = S_LIT;
            end else begin
              state_d = S_MATCH;
            end
          end else begin
            push_s      = 1'b1;
            push_tok_s  = pack_tok(1'b1, 8'd0, m_off_q, m_len_q);
            pend_byte_d = bus.in_byte;
            pend_v_d    = 1'b1;
            state_d     = S_LIT;
          end
        end else if (bus.data_empty) begin
          flush_m_d = 1'b1;
          state_d   = S_FLUSH;
        end else begin
          state_d = S_MATCH;
        end
      end
      S_FLUSH: begin
        if (room_s) begin
          push_s = 1'b1;
          if (flush_m_q) begin
            push_tok_s = pack_tok(1'b1, 8'd0, m_off_q, m_len_q);
            flush_m_d  = 1'b0;
          end else if (pend_v_q) begin
            push_tok_s = pack_tok(1'b0, pend_byte_q, '0, 8'd0);
            pend_v_d   = 1'b0;
          end else begin
            push_tok_s = pack_tok(1'b1, 8'd0, '0, 8'd0);
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.in_valid && ((state_q == S_LIT) || (state_q == S_MATCH))) begin
      hraddr_d = m_src_d[OFF_WIDTH-1:0];
    end else begin
      hraddr_d = hraddr_q;
    end
  end

  always_comb begin
    pop_s       = tok_valid_q & bus.tok_ready;
    push_ok_s   = push_s & (room_s | pop_s);
    cnt_d       = cnt_q + {2'b00, push_ok_s} - {2'b00, pop_s};
    wr_ptr_d    = push_ok_s ? (wr_ptr_q + 2'd1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + 2'd1) : rd_ptr_q;
    fo_full_d   = (cnt_d >= 3'd2);
    tok_valid_d = (cnt_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_byte_q <= 8'd0;
      pend_v_q    <= 1'b0;
      m_off_q     <= '0;
      m_len_q     <= 8'd0;
      m_src_q     <= '0;
      flush_m_q   <= 1'b0;
      hraddr_q    <= '0;
      done_q      <= 1'b0;
      fo_full_q   <= 1'b0;
      tok_valid_q <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      cnt_q       <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_byte_q <= pend_byte_d;
      pend_v_q    <= pend_v_d;
      m_off_q     <= m_off_d;
      m_len_q     <= m_len_d;
      m_src_q     <= m_src_d;
      flush_m_q   <= flush_m_d;
      hraddr_q    <= hraddr_d;
      done_q      <= done_d;
      fo_full_q   <= fo_full_d;
      tok_valid_q <= tok_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_tok_s;
      end
    end
  end

  assign head_s        = mem_q[rd_ptr_q];
  assign bus.hraddr    = hraddr_q;
  assign bus.fo_full   = fo_full_q;
  assign bus.done      = done_q;
  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_type  = head_s[TOK_W-1];
  assign bus.tok_lit   = head_s[TOK_W-2 -: 8];
  assign bus.tok_off   = head_s[8 +: OFF_WIDTH];
  assign bus.tok_len   = head_s[7:0];

  encode_match_ctl_chk #(.CNT_W(3)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .cnt  (cnt_q)
  );
endmodule

// File: tb/tb_encode_match_ctl.sv
// Directed bench for encode_match_ctl: stimulus queues hand-computed tokens,
// an independent monitor pops and compares every accepted token.
`timescale 1ns/1ps
module tb_encode_match_ctl;
  typedef struct packed {
    logic        t;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [7:0]  len;
  } tok_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encode_match_ctl_if #(.LZF_WIDTH(20), .OFF_WIDTH(11)) bus ();

  encode_match_ctl #(.LZF_WIDTH(20), .OFF_WIDTH(11), .MAX_LEN(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tok_t       exp_q[$];
  tok_t       mon_e;
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] hist [0:2047];

  // History memory model of the datapath read port.
  assign bus.hdata = hist[bus.hraddr];

  function automatic tok_t lit(input logic [7:0] b);
    tok_t r;
    r = '0; r.lit = b;
    return r;
  endfunction

  function automatic tok_t mat(input logic [10:0] o, input logic [7:0] l);
    tok_t r;
    r = '0; r.t = 1'b1; r.off = o; r.len = l;
    return r;
  endfunction

  function automatic tok_t endm();
    tok_t r;
    r = '0; r.t = 1'b1;
    return r;
  endfunction

  // Monitor: every accepted head token is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.tok_valid && bus.tok_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL tok_unexpected got t=%0d lit=%02h off=%0d len=%0d",
                 bus.tok_type, bus.tok_lit, bus.tok_off, bus.tok_len);
      end else begin
        mon_e = exp_q.pop_front();
        if ((bus.tok_type !== mon_e.t) ||
            (!mon_e.t && (bus.tok_lit !== mon_e.lit)) ||
            (mon_e.t && ((bus.tok_off !== mon_e.off) || (bus.tok_len !== mon_e.len)))) begin
          tests_failed++;
          $display("FAIL tok got t=%0d lit=%02h off=%0d len=%0d exp t=%0d lit=%02h off=%0d len=%0d",
                   bus.tok_type, bus.tok_lit, bus.tok_off, bus.tok_len,
                   mon_e.t, mon_e.lit, mon_e.off, mon_e.len);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.cand_hit = 1'b0;
  endtask

  task automatic send(input logic [19:0] pos, input logic [7:0] b,
                      input logic hit, input logic [19:0] cpos);
    int w = 0;
    while (bus.fo_full && (w < 200)) begin
      idle();
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("fo_full_stuck", {31'd0, bus.fo_full}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_pos   = pos;
    bus.cand_hit = hit;
    bus.cand_pos = cpos;
    @(posedge clk); #1;
  endtask

  task automatic finish_stream();
    int w = 0;
    idle();
    bus.data_empty = 1'b1;
    while (!(bus.done && (exp_q.size() == 0) && !bus.tok_valid) && (w < 500)) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done", {31'd0, bus.done}, 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);
    bus.data_empty = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_hraddr", {21'd0, bus.hraddr}, 32'd0);
    chk("rst_fo_full", {31'd0, bus.fo_full}, 32'd0);
    chk("rst_tok_valid", {31'd0, bus.tok_valid}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    bus.data_empty = 1'b0;
    bus.tok_ready  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk_reset_vals();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    for (int i = 0; i < 2048; i++) hist[i] = 8'h00;
    bus.in_byte = 8'h00; bus.in_pos = 20'd0; bus.cand_pos = 20'd0;
    idle();
    bus.data_empty = 1'b0;
    bus.tok_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Plain literals.
    s = "ABCD";
    exp_q.push_back(lit("A")); exp_q.push_back(lit("B"));
    exp_q.push_back(lit("C")); exp_q.push_back(lit("D"));
    exp_q.push_back(endm());
    for (int i = 0; i < s.len(); i++) send(20'(i), s[i], 1'b0, 20'd0);
    finish_stream();
    do_reset();

    // Match off=3, extended once, broken by X.
    s = "ABCABCX";
    for (int i = 0; i < s.len(); i++) hist[i] = s[i];
    exp_q.push_back(lit("A")); exp_q.push_back(lit("B")); exp_q.push_back(lit("C"));
    exp_q.push_back(mat(11'd3, 8'd3));
    exp_q.push_back(lit("X")); exp_q.push_back(endm());
    for (int i = 0; i < s.len(); i++) begin
      send(20'(i), s[i], (i == 4), 20'd0);
      if (i == 4) chk("hraddr_open", {21'd0, bus.hraddr}, 32'd2);
      if (i == 5) chk("hraddr_ext", {21'd0, bus.hraddr}, 32'd3);
    end
    finish_stream();
    do_reset();

    // 300 x 0x55: one maximal match, then literals for positions 256..299.
    for (int i = 0; i < 2048; i++) hist[i] = 8'h55;
    exp_q.push_back(lit(8'h55));
    exp_q.push_back(mat(11'd1, 8'd255));
    for (int i = 0; i < 44; i++) exp_q.push_back(lit(8'h55));
    exp_q.push_back(endm());
    for (int i = 0; i < 300; i++) send(20'(i), 8'h55, (i == 2), 20'd0);
    finish_stream();
    do_reset();

    // Offsets 0, 2048 and -1 are all misses.
    s = "KLMN";
    exp_q.push_back(lit("K")); exp_q.push_back(lit("L"));
    exp_q.push_back(lit("M")); exp_q.push_back(lit("N"));
    exp_q.push_back(endm());
    send(20'd3000, s[0], 1'b0, 20'd0);
    send(20'd3001, s[1], 1'b1, 20'd3000);
    send(20'd3002, s[2], 1'b1, 20'd953);
    send(20'd3003, s[3], 1'b1, 20'd3003);
    finish_stream();
    do_reset();

    // Backpressure: consumer stalled, fo_full rises at two entries.
    s = "ABCDEF";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(lit(s[i]));
    exp_q.push_back(endm());
    bus.tok_ready = 1'b0;
    send(20'd0, s[0], 1'b0, 20'd0);
    send(20'd1, s[1], 1'b0, 20'd0);
    chk("fo_full_cnt1", {31'd0, bus.fo_full}, 32'd0);
    send(20'd2, s[2], 1'b0, 20'd0);
    chk("fo_full_cnt2", {31'd0, bus.fo_full}, 32'd1);
    idle();
    repeat (5) @(posedge clk);
    #1;
    chk("stall_fo_full", {31'd0, bus.fo_full}, 32'd1);
    chk("stall_tok_valid", {31'd0, bus.tok_valid}, 32'd1);
    bus.tok_ready = 1'b1;
    for (int i = 3; i < s.len(); i++) send(20'(i), s[i], 1'b0, 20'd0);
    finish_stream();
    do_reset();

    // Reset while a match is open, then a fresh stream.
    send(20'd100, "A", 1'b0, 20'd0);
    send(20'd101, "B", 1'b1, 20'd50);
    chk("hraddr_pre_rst", {21'd0, bus.hraddr}, 32'd52);
    do_reset();
    s = "AB";
    exp_q.push_back(lit("A")); exp_q.push_back(lit("B")); exp_q.push_back(endm());
    for (int i = 0; i < s.len(); i++) send(20'(i), s[i], 1'b0, 20'd0);
    finish_stream();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
